sram_controller: RTL

Responder end of the cache-to-memory interface: accepts 32-bit word writes and 64-bit block reads from the cache controller and executes them on the board's 256K×16 asynchronous SRAM. It sits between the cache controller in the MEM stage and the external SRAM pins. It returns one 64-bit block per read request and holds `ready` low while busy so the pipeline freezes.

---
 rtl/sram_controller_pkg.sv | 30 +++
 rtl/sram_controller_if.sv | 44 ++++
 rtl/sram_controller.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/sram_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sram_controller_pkg
//  Description : Shared definitions for the cache-side SRAM controller:
//                bus and SRAM widths, the default memory base address and
//                the controller state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package sram_controller_pkg;

    // Cache-side bus widths
    localparam int ADDR_W  = 32;
    localparam int WORD_W  = 32;
    localparam int BLOCK_W = 64;

    // External 256K x 16 asynchronous SRAM
    localparam int SRAM_DW = 16;
    localparam int SRAM_AW = 18;

    // Byte address that maps onto SRAM halfword 0
    localparam int unsigned DEFAULT_BASE_ADDR = 1024;

    // Controller state encoding
    localparam int         STATE_W   = 2;
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

endpackage
`default_nettype wire

// File: rtl/sram_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : sram_controller_if
//  Description : Cache-to-memory request bus.
//                master : cache controller (drives requests)
//                slave  : sram_controller (returns block data and ready)
//  Signals     : address   - byte address of the request
//                writeData - word to store
//                wrEn      - word write request
//                rdEn      - 64-bit block read request
//                readData  - last fetched block
//                ready     - request complete / controller idle
//  Revision    : 1.0 - initial release
// ============================================================================
interface sram_controller_if;
    import sram_controller_pkg::*;

    logic [ADDR_W-1:0]  address;
    logic [WORD_W-1:0]  writeData;
    logic               wrEn;
    logic               rdEn;
    logic [BLOCK_W-1:0] readData;
    logic               ready;

    modport master (
        output address,
        output writeData,
        output wrEn,
        output rdEn,
        input  readData,
        input  ready
    );

    modport slave (
        input  address,
        input  writeData,
        input  wrEn,
        input  rdEn,
        output readData,
        output ready
    );

endinterface
`default_nettype wire

// File: rtl/sram_controller.sv
`default_nettype none
// ============================================================================
//  Module      : sram_controller
//  Description : Executes 32-bit word writes and 64-bit block reads from the
//                cache on a 256K x 16 asynchronous SRAM. ready stays low
//                while a transaction is in flight so the pipeline stalls.
//  Ports       : clk        - clock, rising edge
//                rst        - asynchronous active-high reset
//                bus        - cache request bus (slave side)
//                SRAM_DQ    - bidirectional SRAM data
//                SRAM_ADDR  - SRAM halfword address
//                SRAM_WE_N  - SRAM write enable, active low
//                SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N - held low
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int unsigned BASE_ADDR     = DEFAULT_BASE_ADDR,
    parameter int unsigned ACCESS_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    sram_controller_if.slave   bus,
    inout  wire  [SRAM_DW-1:0] SRAM_DQ,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic               SRAM_WE_N,
    output logic               SRAM_UB_N,
    output logic               SRAM_LB_N,
    output logic               SRAM_CE_N,
    output logic               SRAM_OE_N
);

    localparam int                 c_WAIT_W    = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [c_WAIT_W-1:0] c_LAST_WAIT = c_WAIT_W'(ACCESS_CYCLES - 1);
    localparam logic [ADDR_W-1:0]  c_BASE      = ADDR_W'(BASE_ADDR);

    logic [STATE_W-1:0]  r_state;
    logic [STATE_W-1:0]  w_nextState;

    logic                r_isWrite;
    logic [WORD_W-1:0]   r_wdata;
    logic [1:0]          r_hwCnt;
    logic [c_WAIT_W-1:0] r_waitCnt;
    logic [SRAM_AW-1:0]  r_sramAddr;
    logic [BLOCK_W-1:0]  r_readData;

    logic                w_req;
    logic [SRAM_AW-1:0]  w_reqHa;
    logic [SRAM_AW-1:0]  w_reqBase;
    logic                w_lastWait;
    logic                w_lastHw;
    logic                w_ready;
    logic                w_weN;
    logic                w_dqOe;
    logic [SRAM_DW-1:0]  w_dqOut;

    assign w_req   = bus.wrEn | bus.rdEn;
    // Addresses below the base wrap around the top of the SRAM
    assign w_reqHa = SRAM_AW'((bus.address - c_BASE) >> 1);
    // Writes align to a halfword pair, reads to a four-halfword block;
    // a simultaneous read request is dropped in favour of the write
    assign w_reqBase = w_reqHa & (bus.wrEn ? ~18'd1 : ~18'd3);

    assign w_lastWait = (r_waitCnt == c_LAST_WAIT);
    assign w_lastHw   = r_isWrite ? (r_hwCnt == 2'd1) : (r_hwCnt == 2'd3);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE:   if (w_req) w_nextState = ST_ACCESS;
            ST_ACCESS: if (w_lastWait && w_lastHw) w_nextState = ST_DONE;
            ST_DONE:   w_nextState = ST_IDLE;
            default:   w_nextState = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch, counters, SRAM address and read capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_isWrite  <= 1'b0;
            r_wdata    <= '0;
            r_hwCnt    <= 2'd0;
            r_waitCnt  <= '0;
            r_sramAddr <= '0;
            r_readData <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_isWrite  <= bus.wrEn;
                        r_wdata    <= bus.writeData;
                        r_hwCnt    <= 2'd0;
                        r_waitCnt  <= '0;
                        r_sramAddr <= w_reqBase;
                    end
                end
                ST_ACCESS: begin
                    if (w_lastWait) begin
                        // SRAM output has had the full access window to settle
                        if (!r_isWrite) begin
                            r_readData[{r_hwCnt, 4'd0} +: SRAM_DW] <= SRAM_DQ;
                        end
                        r_waitCnt <= '0;
                        if (!w_lastHw) begin
                            r_hwCnt    <= r_hwCnt + 2'd1;
                            r_sramAddr <= r_sramAddr + 18'd1;
                        end
                    end else begin
                        r_waitCnt <= r_waitCnt + c_WAIT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_ready = 1'b0;
        w_weN   = 1'b1;
        w_dqOe  = 1'b0;
        case (r_state)
            ST_IDLE: w_ready = ~w_req;
            ST_ACCESS: begin
                if (r_isWrite) begin
                    w_dqOe = 1'b1;
                    // WE rises on the last wait cycle while address and
                    // data are still held, giving the SRAM its hold time
                    w_weN  = w_lastWait;
                end
            end
            ST_DONE: w_ready = 1'b1;
            default: ;
        endcase
    end

    assign w_dqOut = r_hwCnt[0] ? r_wdata[31:16] : r_wdata[15:0];

    assign SRAM_DQ      = w_dqOe ? w_dqOut : {SRAM_DW{1'bz}};
    assign SRAM_ADDR    = r_sramAddr;
    assign SRAM_WE_N    = w_weN;
    assign SRAM_UB_N    = 1'b0;
    assign SRAM_LB_N    = 1'b0;
    assign SRAM_CE_N    = 1'b0;
    assign SRAM_OE_N    = 1'b0;

    assign bus.readData = r_readData;
    assign bus.ready    = w_ready;

endmodule
`default_nettype wire
